// File: rtl/pin_frame_serializer.sv
// Serializes one captured DATA_W-bit word per generator window as an async frame:
// start(0), data LSB first, parity, stop(1). Reports busy, done, overrun and abort.
module pin_frame_serializer #(
    parameter int DATA_W     = 16,
    parameter bit PARITY_ODD = 1'b0,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              baudrate,
    input  logic              en_clk_B,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic              abort
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] shadow, shadow_n, shift, shift_n;
    logic              shadow_par, shadow_par_n, par, par_n;
    logic              pending, pending_n;
    logic [CNT_W-1:0]  bitcnt, bitcnt_n;
    logic              tx_n, done_n, ovr_n, abort_n;
    logic              capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tx         <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            abort      <= 1'b0;
            pending    <= 1'b0;
            shadow     <= '0;
            shadow_par <= 1'b0;
            shift      <= '0;
            par        <= 1'b0;
            bitcnt     <= '0;
        end else begin
            state      <= state_n;
            tx         <= tx_n;
            busy       <= (state_n != S_IDLE);
            frame_done <= done_n;
            overrun    <= ovr_n;
            abort      <= abort_n;
            pending    <= pending_n;
            shadow     <= shadow_n;
            shadow_par <= shadow_par_n;
            shift      <= shift_n;
            par        <= par_n;
            bitcnt     <= bitcnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        tx_n         = tx;
        done_n       = 1'b0;
        ovr_n        = 1'b0;
        abort_n      = 1'b0;
        pending_n    = pending;
        shadow_n     = shadow;
        shadow_par_n = shadow_par;
        shift_n      = shift;
        par_n        = par;
        bitcnt_n     = bitcnt;

        // A word is accepted only into an empty shadow while the line is idle.
        capture = load && !pending && (state == S_IDLE);
        if (capture) begin
            shadow_n     = data_in;
            shadow_par_n = (^data_in) ^ PARITY_ODD;
            pending_n    = 1'b1;
        end else if (load) begin
            ovr_n = 1'b1;
        end

        // Losing the window mid-frame wins over any baud tick in the same cycle.
        if (state != S_IDLE && !en_clk_B) begin
            state_n = S_IDLE;
            tx_n    = IDLE_LEVEL;
            abort_n = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    tx_n = IDLE_LEVEL;
                    if (pending && en_clk_B) begin
                        state_n   = S_START;
                        shift_n   = shadow;
                        par_n     = shadow_par;
                        pending_n = 1'b0;
                        tx_n      = 1'b0;
                    end
                end
                S_START: if (baudrate) begin
                    state_n  = S_DATA;
                    bitcnt_n = '0;
                    tx_n     = shift[0];
                end
                S_DATA: if (baudrate) begin
                    if (bitcnt == CNT_W'(DATA_W - 1)) begin
                        state_n = S_PARITY;
                        tx_n    = par;
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                        shift_n  = shift >> 1;
                        tx_n     = shift[1];
                    end
                end
                S_PARITY: if (baudrate) begin
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end
                S_STOP: if (baudrate) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    tx_n    = IDLE_LEVEL;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/pin_frame_serializer.md
Name: pin_frame_serializer

Overview:
- Downstream stage of the pin signal generator in the pin communication path, module A.
- Consumes the generator's load, baudrate and en_clk_B strobes.
- On each load it captures a 16-bit data word, then shifts out one 19-bit asynchronous frame on the tx pin: start, 16 data bits LSB first, parity, stop. This exactly fills the generator's 19-bit-period enable window.
- Reports busy, frame completion, overrun and aborted frames.

Parameters:
- DATA_W, 16, data bits per frame; frame length = DATA_W + 3, 19 at default.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
- IDLE_LEVEL, 1, tx level when no frame is active (line idle).

Ports:
- clk  input  1  system clock, same domain as the signal generator.
- rst  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe from the generator; capture data_in.
- baudrate  input  1  one-cycle tick at the end of each bit period; valid only while en_clk_B=1.
- en_clk_B  input  1  frame window enable from the generator.
- data_in  input  DATA_W  word to transmit; sampled only on load.
- tx  output  1  serial pin output, registered.
- busy  output  1  high from the cycle after START entry until the return to IDLE.
- frame_done  output  1  one-cycle pulse when the stop bit period completes.
- overrun  output  1  one-cycle pulse when load arrives while a word is already pending or a frame is in progress.
- abort  output  1  one-cycle pulse when en_clk_B falls while state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, tx=IDLE_LEVEL, busy=0, frame_done=0, overrun=0, abort=0.
  - pending=0, shift register=0, bit counter=0.
- Capture:
  - load=1 with pending=0 and state=IDLE: shadow <= data_in and pending <= 1, next edge.
  - load=1 otherwise: shadow unchanged; overrun pulses next cycle.
  - Parity is computed at capture: XOR of data_in, XOR PARITY_ODD. It is stored with the shadow.
- States:
  - IDLE: tx=IDLE_LEVEL. If pending=1 and en_clk_B=1, go to START.
    - Same edge: shift <= shadow, pending <= 0, tx <= 0.
  - START: hold tx=0. On baudrate, go to DATA with bitcnt=0 and tx <= shift[0].
  - DATA: on baudrate:
    - If bitcnt=DATA_W-1, go to PARITY and tx <= parity bit.
    - Otherwise bitcnt++, shift right by 1, tx <= next bit.
  - PARITY: on baudrate, go to STOP and tx <= 1.
  - STOP: on baudrate, go to IDLE; frame_done pulses the next cycle; tx stays 1.
- Timing:
  - tx is registered: each bit level is driven from the cycle after the baudrate tick that ends the previous bit.
  - Start bit begins 1 cycle after en_clk_B first rises with pending=1.
  - Total frame = 1 + DATA_W + 2 = 19 baud ticks.
- Abort:
  - If en_clk_B=0 in any non-IDLE state, go to IDLE: tx <= IDLE_LEVEL, abort pulses, the word is dropped.
  - Abort has priority over a simultaneous baudrate tick.
- baudrate=1 in IDLE is ignored.
- load on the same edge as IDLE→START: overrun pulses; the shadow is not overwritten in that cycle.
- en_clk_B held high with no pending word: stays IDLE, tx idle.
- bitcnt width = $clog2(DATA_W); no wrap beyond DATA_W-1.
- Reset mid-frame: immediate return to the reset values above on the next edge; no frame_done or abort pulse.

Test Plan:
- Bench runs at generator defaults BAUD=10, SEND_RATE=300, even parity.
- Basic frame: data_in=16'hA5C3 on load, en_clk_B window of 190 cycles.
  - Required tx: 0, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then parity 0, then stop 1.
  - Each bit lasts 10 cycles; frame_done pulses once; busy=0 afterwards.
- Odd parity: PARITY_ODD=1, data_in=16'h0001 → parity bit=0. data_in=16'h0000 → parity bit=1.
- Overrun: second load 5 cycles after the first, before the window opens.
  - overrun pulses once; the transmitted frame carries the first word.
- Abort: en_clk_B dropped after 7 baud ticks.
  - abort pulses; tx returns to 1 next cycle; no frame_done; the next load/window sends a clean frame.
- Reset mid-frame: rst asserted during DATA bit 9.
  - Next cycle tx=1, busy=0, all pulses 0; the following frame is correct.
- Back-to-back: three consecutive SEND_RATE periods with words 16'h0000, 16'hFFFF, 16'h8001.
  - Three correct frames, no overrun, tx=1 between frames.
